// File: rtl/cycle_sequencer.sv
// Hardwired FETCH/EXEC sequencer driven by the T0..T7 beat ring; SEQ_STEP_EN adds single-step.
// Latency: strobes are combinational in the beat cycle; machine state advances on T7 edges.
// No backpressure: start/halt_req are latched as pending requests until the FSM can act.
module cycle_sequencer #(
  parameter int         CNT_W  = 16,
  parameter logic [3:0] HLT_OP = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             T0,
  input  logic             T1,
  input  logic             T2,
  input  logic             T3,
  input  logic             T4,
  input  logic             T5,
  input  logic             T6,
  input  logic             T7,
  input  logic             start,
  input  logic             halt_req,
  input  logic [3:0]       opcode,
`ifdef SEQ_STEP_EN
  input  logic             step_mode,
`endif
  output logic             mar_ld,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ir_ld,
  output logic             pc_inc,
  output logic             alu_en,
  output logic             alu_sub,
  output logic             acc_ld,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             ill_op,
  output logic             beat_err
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_FETCH = 2'b01;
  localparam logic [1:0] S_EXEC  = 2'b10;
  localparam logic [1:0] S_HALT  = 2'b11;

  logic [7:0] beats;
  logic       beat_bad;
  logic       run_ok;
  logic       adv;
  logic       go;
  logic       step;
  logic       leave_wait;
  logic       enter_halt;
  logic       op_ill;
  logic [1:0] nstate;
  logic [3:0] ir_op;
  logic       start_pend;
  logic       halt_pend;

  assign beats    = {T7, T6, T5, T4, T3, T2, T1, T0};
  // All-zero beats are only legal while parked in IDLE.
  assign beat_bad = (state != S_IDLE) && !$onehot(beats);
  assign run_ok   = !beat_err && !beat_bad;
  assign adv      = T7 && run_ok;
  assign go       = start_pend || start;

`ifdef SEQ_STEP_EN
  assign step = step_mode;
`else
  assign step = 1'b0;
`endif

  assign op_ill = (ir_op > 4'd4) && (ir_op != HLT_OP);

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (go) nstate = S_FETCH;
      S_FETCH: nstate = S_EXEC;
      S_EXEC:  nstate = (ir_op == HLT_OP || halt_pend || halt_req || step) ? S_HALT : S_FETCH;
      S_HALT:  if (go) nstate = S_FETCH;
      default: nstate = S_IDLE;
    endcase
  end

  assign leave_wait = adv && (state == S_IDLE || state == S_HALT) && go;
  assign enter_halt = adv && (state == S_EXEC) && (nstate == S_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ir_op      <= 4'h0;
      instr_cnt  <= '0;
      ill_op     <= 1'b0;
      beat_err   <= 1'b0;
      start_pend <= 1'b0;
      halt_pend  <= 1'b0;
    end else begin
      if (beat_bad) beat_err <= 1'b1;
      if (run_ok) begin
        if (adv) state <= nstate;
        if (leave_wait)    start_pend <= 1'b0;
        else if (start)    start_pend <= 1'b1;
        if (enter_halt)    halt_pend <= 1'b0;
        else if (halt_req) halt_pend <= 1'b1;
        if (state == S_FETCH && T2) ir_op <= opcode;
        if (state == S_EXEC && T0 && op_ill) ill_op <= 1'b1;
        if (state == S_EXEC && T7) instr_cnt <= instr_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    mar_ld  = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    ir_ld   = 1'b0;
    pc_inc  = 1'b0;
    alu_en  = 1'b0;
    alu_sub = 1'b0;
    acc_ld  = 1'b0;
    if (!beat_err) begin
      if (state == S_FETCH) begin
        mar_ld = T0;
        mem_rd = T1;
        ir_ld  = T2;
        pc_inc = T3;
      end else if (state == S_EXEC && ir_op != HLT_OP) begin
        case (ir_op)
          4'd1: begin
            mar_ld = T0;
            mem_rd = T1;
            acc_ld = T2;
          end
          4'd2: begin
            mar_ld = T0;
            mem_wr = T1;
          end
          4'd3, 4'd4: begin
            mar_ld  = T0;
            mem_rd  = T1;
            alu_en  = T2;
            alu_sub = T2 && (ir_op == 4'd4);
            acc_ld  = T3;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
